// File: rtl/lb_window_2x2_if.sv
// Bus bundle for the 2x2 stencil window stage: config port, the two
// incoming pixel rows and the window outputs.
interface lb_window_2x2_if #(
  parameter int DATA_WIDTH = 16
);
  // config bus
  logic                  config_en;
  logic [31:0]           config_addr;
  logic [31:0]           config_data;
  logic [31:0]           config_rdata;
  // live row (line buffer data_in stream) and delayed row (line buffer data_out)
  logic [DATA_WIDTH-1:0] cur_in;
  logic                  cur_valid;
  logic [DATA_WIDTH-1:0] lb_in;
  logic                  lb_valid;
  // window outputs
  logic [DATA_WIDTH-1:0] win_00;
  logic [DATA_WIDTH-1:0] win_01;
  logic [DATA_WIDTH-1:0] win_10;
  logic [DATA_WIDTH-1:0] win_11;
  logic                  win_valid;
  logic                  line_end;

  modport master (
    output config_en, config_addr, config_data,
    output cur_in, cur_valid, lb_in, lb_valid,
    input  config_rdata,
    input  win_00, win_01, win_10, win_11, win_valid, line_end
  );

  modport slave (
    input  config_en, config_addr, config_data,
    input  cur_in, cur_valid, lb_in, lb_valid,
    output config_rdata,
    output win_00, win_01, win_10, win_11, win_valid, line_end
  );
endinterface

// File: rtl/lb_window_2x2.sv
// 2x2 sliding stencil window built from the line buffer's delayed row and
// the live row feeding it. Tracks the column against a configured line
// width so the first column of each line never forms a window.
module lb_window_2x2 #(
  parameter int DATA_WIDTH = 16,
  parameter int COL_WIDTH  = 13
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            clk_en,
  input  logic            flush,
  lb_window_2x2_if.slave  bus
);

  logic [COL_WIDTH-1:0]  w_reg, w_next;
  logic                  enable_reg, enable_next;
  logic [COL_WIDTH-1:0]  col_reg, col_next;
  logic [DATA_WIDTH-1:0] win_00_reg, win_00_next;
  logic [DATA_WIDTH-1:0] win_01_reg, win_01_next;
  logic [DATA_WIDTH-1:0] win_10_reg, win_10_next;
  logic [DATA_WIDTH-1:0] win_11_reg, win_11_next;
  logic                  win_valid_reg, win_valid_next;
  logic                  line_end_reg, line_end_next;

  logic                  cfg_wr;
  logic                  accept;
  logic                  w_ok;
  logic [COL_WIDTH-1:0]  w_last;
  logic                  at_last_col;
  logic                  unused_ok;

  assign cfg_wr      = clk_en & bus.config_en & (bus.config_addr == 32'd0);
  assign w_ok        = (w_reg >= COL_WIDTH'(2));
  assign accept      = clk_en & bus.cur_valid & enable_reg & w_ok;
  assign w_last      = w_reg - COL_WIDTH'(1);
  assign at_last_col = (col_reg == w_last);

  // Config fields above the enable bit are don't-care.
  assign unused_ok = ^bus.config_data[31:COL_WIDTH+1];

  // Next-state: config write beats flush, flush beats accept; a cycle
  // without accept drops the one-cycle flags.
  always_comb begin
    w_next         = w_reg;
    enable_next    = enable_reg;
    col_next       = col_reg;
    win_00_next    = win_00_reg;
    win_01_next    = win_01_reg;
    win_10_next    = win_10_reg;
    win_11_next    = win_11_reg;
    win_valid_next = win_valid_reg;
    line_end_next  = line_end_reg;
    if (clk_en) begin
      if (cfg_wr) begin
        w_next         = bus.config_data[COL_WIDTH-1:0];
        enable_next    = bus.config_data[COL_WIDTH];
        col_next       = '0;
        win_valid_next = 1'b0;
        line_end_next  = 1'b0;
      end else if (flush) begin
        col_next       = '0;
        win_00_next    = '0;
        win_01_next    = '0;
        win_10_next    = '0;
        win_11_next    = '0;
        win_valid_next = 1'b0;
        line_end_next  = 1'b0;
      end else if (accept) begin
        win_00_next    = win_01_reg;
        win_01_next    = bus.lb_in;
        win_10_next    = win_11_reg;
        win_11_next    = bus.cur_in;
        col_next       = at_last_col ? '0 : col_reg + COL_WIDTH'(1);
        // column 0 has no older neighbour on this line, so no window yet
        win_valid_next = bus.lb_valid & (col_reg != '0);
        line_end_next  = at_last_col;
      end else begin
        win_valid_next = 1'b0;
        line_end_next  = 1'b0;
      end
    end
  end

  // State registers; clk_en gating is folded into the next-state logic.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      w_reg         <= '0;
      enable_reg    <= 1'b0;
      col_reg       <= '0;
      win_00_reg    <= '0;
      win_01_reg    <= '0;
      win_10_reg    <= '0;
      win_11_reg    <= '0;
      win_valid_reg <= 1'b0;
      line_end_reg  <= 1'b0;
    end else begin
      w_reg         <= w_next;
      enable_reg    <= enable_next;
      col_reg       <= col_next;
      win_00_reg    <= win_00_next;
      win_01_reg    <= win_01_next;
      win_10_reg    <= win_10_next;
      win_11_reg    <= win_11_next;
      win_valid_reg <= win_valid_next;
      line_end_reg  <= line_end_next;
    end
  end

  assign bus.win_00       = win_00_reg;
  assign bus.win_01       = win_01_reg;
  assign bus.win_10       = win_10_reg;
  assign bus.win_11       = win_11_reg;
  // Flags are masked while the stage is frozen and reappear when it resumes.
  assign bus.win_valid    = win_valid_reg & clk_en;
  assign bus.line_end     = line_end_reg & clk_en;
  assign bus.config_rdata = 32'({enable_reg, w_reg});

endmodule

// File: tb/tb_lb_window_2x2.sv
// Directed bench for lb_window_2x2 with hand-computed expected values.
module tb_lb_window_2x2;

  logic clk_in;
  logic reset;
  logic clk_en;
  logic flush;
  int   n_tests;
  int   n_fail;

  lb_window_2x2_if #(.DATA_WIDTH(16)) bus ();

  lb_window_2x2 #(.DATA_WIDTH(16), .COL_WIDTH(13)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .clk_en (clk_en),
    .flush  (flush),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic check_win(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
    check({tag, ".w00"}, 32'(bus.win_00), 32'(a));
    check({tag, ".w01"}, 32'(bus.win_01), 32'(b));
    check({tag, ".w10"}, 32'(bus.win_10), 32'(c));
    check({tag, ".w11"}, 32'(bus.win_11), 32'(d));
  endtask

  // advance one clock, leaving us 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cfg_write(input logic [31:0] data);
    bus.config_en   = 1'b1;
    bus.config_addr = 32'd0;
    bus.config_data = data;
    tick();
    bus.config_en   = 1'b0;
  endtask

  // one accepted pixel pair, then check win_valid and line_end
  task automatic push(input string tag, input logic [15:0] cur, input logic [15:0] lb,
                      input logic lbv, input logic exp_valid, input logic exp_end);
    bus.cur_in    = cur;
    bus.lb_in     = lb;
    bus.lb_valid  = lbv;
    bus.cur_valid = 1'b1;
    tick();
    check({tag, ".valid"}, 32'(bus.win_valid), 32'(exp_valid));
    check({tag, ".end"},   32'(bus.line_end),  32'(exp_end));
  endtask

  task automatic idle();
    bus.cur_valid = 1'b0;
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    clk_en  = 1'b1;
    flush   = 1'b0;
    bus.config_en   = 1'b0;
    bus.config_addr = 32'd0;
    bus.config_data = 32'd0;
    bus.cur_in      = '0;
    bus.cur_valid   = 1'b0;
    bus.lb_in       = '0;
    bus.lb_valid    = 1'b0;

    // 1: reset, then first config
    repeat (3) tick();
    check("rst.valid", 32'(bus.win_valid), 32'd0);
    check("rst.end",   32'(bus.line_end),  32'd0);
    check("rst.rdata", bus.config_rdata, 32'd0);
    check_win("rst", 16'd0, 16'd0, 16'd0, 16'd0);
    reset = 1'b1;
    tick();
    cfg_write(32'h0000_200F);
    check("cfg1.rdata", bus.config_rdata, 32'h0000_200F);
    check("cfg1.valid", 32'(bus.win_valid), 32'd0);
    check_win("cfg1", 16'd0, 16'd0, 16'd0, 16'd0);

    // 2: W=4, line buffer still filling
    cfg_write(32'h0000_2004);
    push("fill1", 16'd1, 16'd0, 1'b0, 1'b0, 1'b0);
    push("fill2", 16'd2, 16'd0, 1'b0, 1'b0, 1'b0);
    push("fill3", 16'd3, 16'd0, 1'b0, 1'b0, 1'b0);
    push("fill4", 16'd4, 16'd0, 1'b0, 1'b0, 1'b1);
    idle();
    check("fill.end_drop", 32'(bus.line_end), 32'd0);
    check_win("fill", 16'd0, 16'd0, 16'd3, 16'd4);

    // 3: full line with previous row available
    push("row1", 16'd5, 16'd1, 1'b1, 1'b0, 1'b0);
    push("row2", 16'd6, 16'd2, 1'b1, 1'b1, 1'b0);
    check_win("row2", 16'd1, 16'd2, 16'd5, 16'd6);
    push("row3", 16'd7, 16'd3, 1'b1, 1'b1, 1'b0);
    push("row4", 16'd8, 16'd4, 1'b1, 1'b1, 1'b1);
    check_win("row4", 16'd3, 16'd4, 16'd7, 16'd8);
    idle();
    check("row.valid_drop", 32'(bus.win_valid), 32'd0);

    // 4: flush mid-line
    push("pf1", 16'd9,  16'd5, 1'b1, 1'b0, 1'b0);
    push("pf2", 16'd10, 16'd6, 1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    bus.cur_in = 16'd55;
    bus.lb_in  = 16'd55;
    bus.cur_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("flush.valid", 32'(bus.win_valid), 32'd0);
      check("flush.end",   32'(bus.line_end),  32'd0);
    end
    check_win("flush", 16'd0, 16'd0, 16'd0, 16'd0);
    check("flush.rdata", bus.config_rdata, 32'h0000_2004);
    flush = 1'b0;
    push("af1", 16'd11, 16'd7, 1'b1, 1'b0, 1'b0);
    check_win("af1", 16'd0, 16'd7, 16'd0, 16'd11);
    push("af2", 16'd12, 16'd8, 1'b1, 1'b1, 1'b0);
    push("af3", 16'd13, 16'd9, 1'b1, 1'b1, 1'b0);
    push("af4", 16'd14, 16'd10, 1'b1, 1'b1, 1'b1);

    // 5: clock-enable stall mid-line
    push("ce1", 16'd21, 16'd17, 1'b1, 1'b0, 1'b0);
    push("ce2", 16'd22, 16'd18, 1'b1, 1'b1, 1'b0);
    clk_en = 1'b0;
    bus.cur_in = 16'd99;
    bus.lb_in  = 16'd99;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall.valid", 32'(bus.win_valid), 32'd0);
    end
    check_win("stall", 16'd17, 16'd18, 16'd21, 16'd22);
    bus.cur_valid = 1'b0;
    clk_en = 1'b1;
    #1;
    check("resume.held_valid", 32'(bus.win_valid), 32'd1);
    push("ce3", 16'd23, 16'd19, 1'b1, 1'b1, 1'b0);
    check_win("ce3", 16'd18, 16'd19, 16'd22, 16'd23);
    push("ce4", 16'd24, 16'd20, 1'b1, 1'b1, 1'b1);

    // W below 2 never accepts
    cfg_write(32'h0000_2001);
    push("w1", 16'd50, 16'd50, 1'b1, 1'b0, 1'b0);
    check_win("w1", 16'd19, 16'd20, 16'd23, 16'd24);
    cfg_write(32'h0000_2004);

    // 6: disable mid-line, then async reset
    push("d1", 16'd31, 16'd27, 1'b1, 1'b0, 1'b0);
    push("d2", 16'd32, 16'd28, 1'b1, 1'b1, 1'b0);
    bus.cur_in = 16'd77;
    bus.cur_valid = 1'b1;
    cfg_write(32'h0000_0004);
    check("dis.rdata", bus.config_rdata, 32'h0000_0004);
    check("dis.valid", 32'(bus.win_valid), 32'd0);
    check("dis.cur_dropped", 32'(bus.win_11), 32'd32);
    push("dis2", 16'd78, 16'd78, 1'b1, 1'b0, 1'b0);
    check("dis2.no_accept", 32'(bus.win_11), 32'd32);
    cfg_write(32'h0000_2004);
    push("re1", 16'd40, 16'd36, 1'b1, 1'b0, 1'b0);
    push("re2", 16'd41, 16'd37, 1'b1, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("areset.valid", 32'(bus.win_valid), 32'd0);
    check("areset.end",   32'(bus.line_end),  32'd0);
    check("areset.rdata", bus.config_rdata, 32'd0);
    check_win("areset", 16'd0, 16'd0, 16'd0, 16'd0);
    tick();
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lb_window_2x2.md
Name: lb_window_2x2

Overview:
- Downstream consumer of the memory-core line buffer.
- Pairs the delayed row from the line buffer (data_out/valid_out) with the live row that feeds the line buffer's data_in.
- Builds a sliding 2x2 stencil window, tracks columns against a configured line width, and flags window validity and line ends.
- Sits between the line-buffer memory core and the downstream PE stencil arithmetic.

Parameters:
DATA_WIDTH, 16, pixel width of cur_in, lb_in and all window outputs
COL_WIDTH, 13, width of line-width config field and column counter

Ports:
clk_in  input  1  clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
clk_en  input  1  global clock enable; low freezes all state
flush  input  1  synchronous clear of datapath state; config retained
config_en  input  1  config write strobe
config_addr  input  32  config address; only address 0 is decoded
config_data  input  32  [12:0] line width W, [13] enable, rest ignored
cur_in  input  DATA_WIDTH  current-row pixel (same stream as line buffer data_in)
cur_valid  input  1  cur_in valid (same as line buffer wen_in)
lb_in  input  DATA_WIDTH  previous-row pixel from line buffer data_out
lb_valid  input  1  line buffer valid_out
win_00  output  DATA_WIDTH  previous row, older column
win_01  output  DATA_WIDTH  previous row, newer column
win_10  output  DATA_WIDTH  current row, older column
win_11  output  DATA_WIDTH  current row, newer column
win_valid  output  1  window holds a complete 2x2 stencil
line_end  output  1  one-cycle pulse: last column of a line accepted
config_rdata  output  32  {18'b0, enable, W}

Behaviour:
- Reset (reset=0, async): W=0, enable=0, col=0, all window regs=0, win_valid=0, line_end=0.
- accept = clk_en & cur_valid & enable & (W>=2).
- Config write when clk_en & config_en & config_addr==0:
  - W and enable load from config_data.
  - col cleared and win_valid cleared in the same cycle.
  - Any accept in that cycle is dropped.
- flush=1 with clk_en=1:
  - col, window regs, win_valid and line_end clear next edge.
  - Flush has priority over accept and is lower priority than a config write.
- On accept:
  - win_00<=win_01, win_01<=lb_in.
  - win_10<=win_11, win_11<=cur_in.
  - col<=(col==W-1)?0:col+1.
- win_valid is registered, latency 1 cycle after accept.
  - Next-state value = accept & lb_valid & (col!=0), where col is the pre-increment value.
  - Cleared on any cycle without accept.
  - First column of each line never yields a window, so there is no wrap across lines.
- line_end is registered: next-state value = accept & (col==W-1).
- accept with lb_valid=0 (line buffer still filling):
  - Window still shifts and col still advances.
  - win_valid stays 0.
- clk_en=0:
  - No register updates.
  - win_valid and line_end outputs are gated to 0 combinationally.
  - They reappear at their held values when clk_en returns.
- W<2 or enable=0: no accepts; outputs hold their last values except win_valid=0 and line_end=0.
- col is COL_WIDTH bits. W=8191 wraps at 8190. col never exceeds W-1.
- Async reset mid-line returns all state to reset values immediately. Config is lost.

Test Plan:
1. Reset low 3 cycles, then config_data=0x200F (W=15, en=1) at addr 0 -> config_rdata=0x0000200F; all window outputs 0, win_valid=0.
2. W=4, lb_valid=0, cur_in=1,2,3,4 on consecutive cycles -> win_valid never 1; line_end pulses once, one cycle after cur_in=4; col returns to 0.
3. W=4, lb_valid=1, lb_in=cur_in-4, cur_in=5..8 -> win_valid=1 after pixels 6, 7, 8 (3 windows). Last window: win_00=3, win_01=4, win_10=7, win_11=8.
4. Mid-line flush=1 for 5 cycles with cur_valid=1 -> win_valid=0, col=0, window regs=0; next accepted pixel treated as column 0; config_rdata unchanged.
5. clk_en=0 for 5 cycles during a streaming line -> window regs and col unchanged; win_valid=0 while low; stream resumes exactly where it stopped.
6. Write config with enable=0 mid-line -> col=0, no further accepts. Then assert reset=0 asynchronously between clock edges -> all outputs 0 immediately, config_rdata=0.
